// File: rtl/pipeline_pkg.sv
// Shared front-end pipeline types and constants, used by the IF/ID, ID/EX and EX stages.
package pipeline_pkg;

    localparam int unsigned PKG_XLEN  = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [31:0]         instr;
        logic                valid;
    } if_id_t;

    // Per-cycle action chosen for a front-end register.
    typedef enum logic [1:0] {
        FE_ADVANCE = 2'd0,
        FE_HOLD    = 2'd1,
        FE_FLUSH   = 2'd2
    } fe_action_e;

    function automatic if_id_t if_id_bubble(input logic [PKG_XLEN-1:0] pc,
                                            input logic [31:0]         nop);
        if_id_t b;
        b.pc    = pc;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_id_pipeline_ctrl.sv
// PC and IF/ID register owner: applies flush, hazard-unit holds and normal advance,
// and keeps saturating stall/flush counters.
module if_id_pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(pipeline_pkg::RESET_PC),
    parameter logic [31:0]      NOP_INSTR = pipeline_pkg::NOP_INSTR,
    parameter int unsigned      CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_Write,
    input  logic             IF_ID_Write,
    input  logic             Stall,
    input  logic             Branch_Taken,
    input  logic [XLEN-1:0]  Branch_Target,
    input  logic [31:0]      IMem_Instr,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  IF_ID_PC,
    output logic [31:0]      IF_ID_Instr,
    output logic             IF_ID_Valid,
    output logic             ID_EX_Bubble,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    fe_action_e      pc_act, if_id_act;
    logic            stall_inc;

    // The branch in EX is older than any load-use in ID, so it overrides both enables.
    always_comb begin
        pc_act    = FE_HOLD;
        if_id_act = FE_HOLD;
        if (Branch_Taken) begin
            pc_act    = FE_FLUSH;
            if_id_act = FE_FLUSH;
        end else begin
            if (PC_Write)    pc_act    = FE_ADVANCE;
            if (IF_ID_Write) if_id_act = FE_ADVANCE;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (pc_act)
            FE_FLUSH:   pc_d = Branch_Target;
            FE_ADVANCE: pc_d = pc_q + XLEN'(4);
            default:    pc_d = pc_q;
        endcase
    end

    always_comb begin
        if_id_d = if_id_q;
        unique case (if_id_act)
            FE_FLUSH: begin
                if_id_d = if_id_bubble(PKG_XLEN'(pc_q), NOP_INSTR);
            end
            FE_ADVANCE: begin
                if_id_d.pc    = PKG_XLEN'(pc_q);
                if_id_d.instr = IMem_Instr;
                if_id_d.valid = 1'b1;
            end
            default: if_id_d = if_id_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            if_id_q <= if_id_bubble('0, NOP_INSTR);
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign PC           = pc_q;
    assign IF_ID_PC     = XLEN'(if_id_q.pc);
    assign IF_ID_Instr  = if_id_q.instr;
    assign IF_ID_Valid  = if_id_q.valid;
    assign ID_EX_Bubble = Stall | Branch_Taken;
    assign stall_inc    = Stall & ~Branch_Taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Branch_Taken),
        .clr   (1'b0),
        .count (Flush_Count)
    );

endmodule

// File: tb/tb_if_id_pipeline_ctrl.sv
// Self-checking bench for if_id_pipeline_ctrl: reference model feeds a scoreboard queue,
// a monitor pops one expectation per edge; scenario tasks add targeted checks.
module tb_if_id_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, PC_Write, IF_ID_Write, Stall, Branch_Taken;
    logic [31:0] Branch_Target, IMem_Instr;
    logic [31:0] PC, IF_ID_PC, IF_ID_Instr, Stall_Count, Flush_Count;
    logic        IF_ID_Valid, ID_EX_Bubble;
    logic [31:0] PC4, IF_ID_PC4, IF_ID_Instr4;
    logic        IF_ID_Valid4, ID_EX_Bubble4;
    logic [3:0]  Stall_Count4, Flush_Count4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc, ifid_pc, instr;
        logic        valid;
        logic [31:0] sc, fc;
        logic [3:0]  sc4, fc4;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    always #5 clk = ~clk;

    if_id_pipeline_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .Stall(Stall), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .IMem_Instr(IMem_Instr), .PC(PC), .IF_ID_PC(IF_ID_PC), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_Valid(IF_ID_Valid), .ID_EX_Bubble(ID_EX_Bubble),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    if_id_pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .Stall(Stall), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .IMem_Instr(IMem_Instr), .PC(PC4), .IF_ID_PC(IF_ID_PC4), .IF_ID_Instr(IF_ID_Instr4),
        .IF_ID_Valid(IF_ID_Valid4), .ID_EX_Bubble(ID_EX_Bubble4),
        .Stall_Count(Stall_Count4), .Flush_Count(Flush_Count4)
    );

    // Drive one cycle of inputs at the falling edge and push the model's post-edge state.
    task automatic apply(input logic r, input logic pw, input logic iw, input logic st,
                         input logic bt, input logic [31:0] tgt, input logic [31:0] im);
        @(negedge clk);
        rst = r; PC_Write = pw; IF_ID_Write = iw; Stall = st;
        Branch_Taken = bt; Branch_Target = tgt; IMem_Instr = im;
        if (r) begin
            m.pc = 32'h0; m.ifid_pc = 32'h0; m.instr = 32'h13; m.valid = 1'b0;
            m.sc = 0; m.fc = 0; m.sc4 = 0; m.fc4 = 0;
        end else if (bt) begin
            m.ifid_pc = m.pc; m.instr = 32'h13; m.valid = 1'b0; m.pc = tgt;
            if (m.fc  != 32'hFFFF_FFFF) m.fc  = m.fc + 1;
            if (m.fc4 != 4'hF)          m.fc4 = m.fc4 + 1;
        end else begin
            if (iw) begin m.ifid_pc = m.pc; m.instr = im; m.valid = 1'b1; end
            if (pw) m.pc = m.pc + 32'd4;
            if (st) begin
                if (m.sc  != 32'hFFFF_FFFF) m.sc  = m.sc + 1;
                if (m.sc4 != 4'hF)          m.sc4 = m.sc4 + 1;
            end
        end
        sb.push_back(m);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic adv(input logic [31:0] im);
        apply(0, 1, 1, 0, 0, 32'h0, im);
        tick();
    endtask

    // Scoreboard monitor: one expectation per active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks += 6;
            if (PC !== e.pc) begin failures++; $display("FAIL sb_pc actual=%h expected=%h", PC, e.pc); end
            if (IF_ID_PC !== e.ifid_pc) begin failures++; $display("FAIL sb_ifid_pc actual=%h expected=%h", IF_ID_PC, e.ifid_pc); end
            if (IF_ID_Instr !== e.instr) begin failures++; $display("FAIL sb_instr actual=%h expected=%h", IF_ID_Instr, e.instr); end
            if (IF_ID_Valid !== e.valid) begin failures++; $display("FAIL sb_valid actual=%b expected=%b", IF_ID_Valid, e.valid); end
            if (Stall_Count !== e.sc) begin failures++; $display("FAIL sb_stall_cnt actual=%0d expected=%0d", Stall_Count, e.sc); end
            if (Flush_Count !== e.fc) begin failures++; $display("FAIL sb_flush_cnt actual=%0d expected=%0d", Flush_Count, e.fc); end
            checks += 2;
            if (Stall_Count4 !== e.sc4) begin failures++; $display("FAIL sb_stall_cnt4 actual=%0d expected=%0d", Stall_Count4, e.sc4); end
            if (Flush_Count4 !== e.fc4) begin failures++; $display("FAIL sb_flush_cnt4 actual=%0d expected=%0d", Flush_Count4, e.fc4); end
        end
    end

    task automatic test_reset();
        apply(1, 1, 1, 0, 0, 32'h0, 32'hDEAD_BEEF); tick();
        apply(1, 1, 1, 0, 0, 32'h0, 32'hDEAD_BEEF); tick();
        checks += 5;
        if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=0", PC); end
        if (IF_ID_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", IF_ID_Valid); end
        if (IF_ID_Instr !== 32'h13) begin failures++; $display("FAIL reset_instr actual=%h expected=13", IF_ID_Instr); end
        if (Stall_Count !== 32'h0) begin failures++; $display("FAIL reset_stall_cnt actual=%0d expected=0", Stall_Count); end
        if (Flush_Count !== 32'h0) begin failures++; $display("FAIL reset_flush_cnt actual=%0d expected=0", Flush_Count); end
        for (int unsigned i = 1; i <= 2; i++) begin
            adv(32'h1000_0000 + i);
            checks++;
            if (PC !== 32'(4 * i)) begin failures++; $display("FAIL reset_step_pc actual=%h expected=%h", PC, 32'(4 * i)); end
        end
    endtask

    task automatic test_stall();
        adv(32'h0000_0A03); adv(32'h0000_0A04);
        checks++;
        if (PC !== 32'h10) begin failures++; $display("FAIL stall_setup_pc actual=%h expected=10", PC); end
        apply(0, 0, 0, 1, 0, 32'h0, 32'h0000_0A05);
        #1;
        checks++;
        if (ID_EX_Bubble !== 1'b1) begin failures++; $display("FAIL stall_bubble actual=%b expected=1", ID_EX_Bubble); end
        tick();
        checks += 3;
        if (PC !== 32'h10) begin failures++; $display("FAIL stall_pc_hold actual=%h expected=10", PC); end
        if (IF_ID_PC !== 32'h0C) begin failures++; $display("FAIL stall_ifid_hold actual=%h expected=0c", IF_ID_PC); end
        if (Stall_Count !== 32'd1) begin failures++; $display("FAIL stall_count actual=%0d expected=1", Stall_Count); end
        apply(0, 1, 1, 0, 0, 32'h0, 32'h0000_0A05);
        #1;
        checks++;
        if (ID_EX_Bubble !== 1'b0) begin failures++; $display("FAIL stall_nobubble actual=%b expected=0", ID_EX_Bubble); end
        tick();
        checks++;
        if (PC !== 32'h14) begin failures++; $display("FAIL stall_resume_pc actual=%h expected=14", PC); end
    endtask

    task automatic test_flush();
        for (int unsigned i = 0; i < 4; i++) adv(32'h0000_0B00 + i);
        apply(0, 1, 1, 0, 1, 32'h200, 32'h0000_0BFF);
        #1;
        checks++;
        if (ID_EX_Bubble !== 1'b1) begin failures++; $display("FAIL flush_bubble actual=%b expected=1", ID_EX_Bubble); end
        tick();
        checks += 5;
        if (PC !== 32'h200) begin failures++; $display("FAIL flush_pc actual=%h expected=200", PC); end
        if (IF_ID_Valid !== 1'b0) begin failures++; $display("FAIL flush_valid actual=%b expected=0", IF_ID_Valid); end
        if (IF_ID_Instr !== 32'h13) begin failures++; $display("FAIL flush_instr actual=%h expected=13", IF_ID_Instr); end
        if (IF_ID_PC !== 32'h24) begin failures++; $display("FAIL flush_ifid_pc actual=%h expected=24", IF_ID_PC); end
        if (Flush_Count !== 32'd1) begin failures++; $display("FAIL flush_count actual=%0d expected=1", Flush_Count); end
        adv(32'h0000_0C00);
        checks += 3;
        if (IF_ID_PC !== 32'h200) begin failures++; $display("FAIL flush_target_ifid_pc actual=%h expected=200", IF_ID_PC); end
        if (IF_ID_Valid !== 1'b1) begin failures++; $display("FAIL flush_target_valid actual=%b expected=1", IF_ID_Valid); end
        if (IF_ID_Instr !== 32'h0000_0C00) begin failures++; $display("FAIL flush_target_instr actual=%h expected=00000c00", IF_ID_Instr); end
    endtask

    task automatic test_simultaneous();
        apply(0, 0, 0, 1, 1, 32'h80, 32'h0000_0D00);
        #1;
        checks++;
        if (ID_EX_Bubble !== 1'b1) begin failures++; $display("FAIL simul_bubble actual=%b expected=1", ID_EX_Bubble); end
        tick();
        checks += 4;
        if (PC !== 32'h80) begin failures++; $display("FAIL simul_pc actual=%h expected=80", PC); end
        if (IF_ID_Valid !== 1'b0) begin failures++; $display("FAIL simul_valid actual=%b expected=0", IF_ID_Valid); end
        if (Stall_Count !== 32'd1) begin failures++; $display("FAIL simul_stall_cnt actual=%0d expected=1", Stall_Count); end
        if (Flush_Count !== 32'd2) begin failures++; $display("FAIL simul_flush_cnt actual=%0d expected=2", Flush_Count); end
    endtask

    task automatic test_mismatch();
        apply(0, 1, 0, 0, 0, 32'h0, 32'h0000_0E00); tick();
        checks++;
        if (PC !== 32'h84 || IF_ID_Valid !== 1'b0) begin failures++; $display("FAIL mismatch_pc_only actual=%h/%b expected=84/0", PC, IF_ID_Valid); end
        apply(0, 0, 1, 0, 0, 32'h0, 32'h0000_0E01); tick();
        checks++;
        if (PC !== 32'h84 || IF_ID_PC !== 32'h84) begin failures++; $display("FAIL mismatch_ifid_only actual=%h/%h expected=84/84", PC, IF_ID_PC); end
    endtask

    task automatic test_wrap();
        apply(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 32'h0); tick();
        adv(32'h0000_0F00);
        checks += 2;
        if (PC !== 32'h0) begin failures++; $display("FAIL wrap_pc actual=%h expected=0", PC); end
        if (IF_ID_PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_ifid_pc actual=%h expected=fffffffc", IF_ID_PC); end
    endtask

    task automatic test_saturation();
        apply(1, 0, 0, 0, 0, 32'h0, 32'h0); tick();
        for (int unsigned i = 0; i < 20; i++) begin
            apply(0, 0, 0, 1, 0, 32'h0, 32'h0); tick();
        end
        checks += 2;
        if (Stall_Count4 !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt4 actual=%0d expected=15", Stall_Count4); end
        if (Stall_Count !== 32'd20) begin failures++; $display("FAIL sat_stall_cnt32 actual=%0d expected=20", Stall_Count); end
        apply(0, 0, 0, 1, 0, 32'h0, 32'h0); tick();
        checks++;
        if (Stall_Count4 !== 4'd15) begin failures++; $display("FAIL sat_stall_hold actual=%0d expected=15", Stall_Count4); end
    endtask

    task automatic test_reset_mid_stall();
        adv(32'h0000_1100);
        apply(0, 0, 0, 1, 0, 32'h0, 32'h0); tick();
        apply(1, 0, 0, 1, 1, 32'h400, 32'h0); tick();
        checks += 5;
        if (PC !== 32'h0) begin failures++; $display("FAIL rst_mid_pc actual=%h expected=0", PC); end
        if (IF_ID_Valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid actual=%b expected=0", IF_ID_Valid); end
        if (IF_ID_PC !== 32'h0) begin failures++; $display("FAIL rst_mid_ifid_pc actual=%h expected=0", IF_ID_PC); end
        if (Stall_Count !== 32'd0) begin failures++; $display("FAIL rst_mid_stall_cnt actual=%0d expected=0", Stall_Count); end
        if (Flush_Count !== 32'd0) begin failures++; $display("FAIL rst_mid_flush_cnt actual=%0d expected=0", Flush_Count); end
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 80; i++) begin
            apply(($urandom_range(0, 30) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 6) == 0), $urandom & 32'hFFFF_FFFC, $urandom);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; PC_Write = 1'b0; IF_ID_Write = 1'b0; Stall = 1'b0;
        Branch_Taken = 1'b0; Branch_Target = '0; IMem_Instr = '0;
        m = '{default: '0};
        test_reset();
        test_stall();
        test_flush();
        test_simultaneous();
        test_mismatch();
        test_wrap();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain actual=%0d expected=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
